// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - word-to-serial UART transmitter fed from a 1-cycle-latency FIFO; optional parity via UART_WORD_TX_PARITY_EN
module uart_word_tx #(
  parameter int CLK_DIV    = 434,
  parameter int WORD_BYTES = 4,
  parameter int MSB_FIRST  = 1,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] data_in,
  input  logic                    empty,
  output logic                    rd_en,
  output logic                    tx,
  output logic [7:0]              data_out,
  output logic                    pulse,
  output logic                    busy
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, PAR, STOP} state_t;

  state_t                  state;
  logic [CW-1:0]           baud_cnt;
  logic [2:0]              bit_idx;
  logic [IW-1:0]           byte_idx;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [7:0]              shift_q;
  logic                    baud_wrap;
  logic [7:0]              load_byte;
  logic [7:0]              next_byte;

  // Byte lane for a given frame index, honouring the configured byte order.
  function automatic logic [7:0] pick(input logic [8*WORD_BYTES-1:0] w, input logic [IW-1:0] idx);
    int pos;
    pos = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - int'(idx)) : int'(idx);
    if (pos < 0 || pos >= WORD_BYTES) pos = 0;
    return w[8*pos +: 8];
  endfunction

  assign baud_wrap = (baud_cnt == CW'(CLK_DIV - 1));
  // First byte comes straight from the FIFO bus because the word register loads on the same edge.
  assign load_byte = pick(data_in, '0);
  assign next_byte = pick(word_q, byte_idx + IW'(1));

`ifdef UART_WORD_TX_PARITY_EN
  logic par_bit;
  // data_out still holds the byte in flight while its data bits shift out.
  assign par_bit = (^data_out) ^ (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Frame sequencer: every output is registered and set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      rd_en    <= 1'b0;
      pulse    <= 1'b0;
      busy     <= 1'b0;
      data_out <= 8'h00;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      shift_q  <= '0;
    end else begin
      rd_en <= 1'b0;
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (!empty) begin
            state <= READ;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: begin
          state <= LOAD;
        end
        LOAD: begin
          word_q   <= data_in;
          byte_idx <= '0;
          shift_q  <= load_byte;
          data_out <= load_byte;
          pulse    <= 1'b1;
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= START;
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            tx       <= shift_q[0];
            shift_q  <= {1'b0, shift_q[7:1]};
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_WORD_TX_PARITY_EN
              tx      <= par_bit;
              state   <= PAR;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        PAR: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              if (byte_idx != IW'(WORD_BYTES - 1)) begin
                byte_idx <= byte_idx + IW'(1);
                data_out <= next_byte;
                shift_q  <= next_byte;
                pulse    <= 1'b1;
                tx       <= 1'b0;
                state    <= START;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - self-checking bench for uart_word_tx across four configurations
module tb_uart_word_tx;

`ifdef UART_WORD_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din = '0;
  logic        empty_v = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  empty_o, tx_o, rd_o, pulse_o, busy_o;
  logic [7:0]  dout_o [4];
  logic        tx_s, rd_s, pulse_s, busy_s;
  logic [7:0]  dout_s;

  int checks = 0;
  int errors = 0;
  logic [63:0] wq[$];
  logic [7:0]  got_bytes[$];
  logic        trace[$];

  always #5 clk = ~clk;

  assign empty_o[0] = (sel == 2'd0) ? empty_v : 1'b1;
  assign empty_o[1] = (sel == 2'd1) ? empty_v : 1'b1;
  assign empty_o[2] = (sel == 2'd2) ? empty_v : 1'b1;
  assign empty_o[3] = (sel == 2'd3) ? empty_v : 1'b1;
  assign tx_s    = tx_o[sel];
  assign rd_s    = rd_o[sel];
  assign pulse_s = pulse_o[sel];
  assign busy_s  = busy_o[sel];
  assign dout_s  = dout_o[sel];

  uart_word_tx #(.CLK_DIV(8), .WORD_BYTES(4), .MSB_FIRST(1), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .data_in(din[31:0]), .empty(empty_o[0]), .rd_en(rd_o[0]),
    .tx(tx_o[0]), .data_out(dout_o[0]), .pulse(pulse_o[0]), .busy(busy_o[0]));
  uart_word_tx #(.CLK_DIV(4), .WORD_BYTES(4), .MSB_FIRST(0), .STOP_BITS(1), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(din[31:0]), .empty(empty_o[1]), .rd_en(rd_o[1]),
    .tx(tx_o[1]), .data_out(dout_o[1]), .pulse(pulse_o[1]), .busy(busy_o[1]));
  uart_word_tx #(.CLK_DIV(4), .WORD_BYTES(2), .MSB_FIRST(1), .STOP_BITS(2), .PARITY_ODD(0)) dut_c (
    .clk(clk), .rst(rst), .data_in(din[15:0]), .empty(empty_o[2]), .rd_en(rd_o[2]),
    .tx(tx_o[2]), .data_out(dout_o[2]), .pulse(pulse_o[2]), .busy(busy_o[2]));
  uart_word_tx #(.CLK_DIV(5), .WORD_BYTES(1), .MSB_FIRST(1), .STOP_BITS(1), .PARITY_ODD(0)) dut_d (
    .clk(clk), .rst(rst), .data_in(din[7:0]), .empty(empty_o[3]), .rd_en(rd_o[3]),
    .tx(tx_o[3]), .data_out(dout_o[3]), .pulse(pulse_o[3]), .busy(busy_o[3]));

  function automatic logic [7:0] get_byte(input logic [63:0] w, input int wb, input int msb, input int b);
    int pos;
    pos = (msb != 0) ? (wb - 1 - b) : b;
    return w[8*pos +: 8];
  endfunction

  // Line level for bit position bp of a frame: start, 8 data LSB-first, optional parity, stop(s).
  function automatic logic exp_bit(input logic [7:0] by, input int bp, input int podd);
    if (bp == 0) return 1'b0;
    if (bp <= 8) return by[bp-1];
    if (PBIT == 1 && bp == 9) return (^by) ^ (podd != 0);
    return 1'b1;
  endfunction

  // Plays the words in wq through DUT s as a FIFO and checks every cycle against a timeline model.
  task automatic run_words(input logic [1:0] s, input int cd, input int wb, input int msb,
                           input int sb, input int podd, input string tag,
                           output int n_rd, output int n_pulse, output int n_busy);
    logic [63:0] words[$];
    logic [63:0] fifo[$];
    logic [63:0] nxt;
    logic        load_next, e_tx, e_rd, e_pulse, e_busy, have_b;
    logic [7:0]  e_b, cur_b;
    int n, f, len, per, total, j, m, r, bp;
    words = wq; fifo = wq; n = words.size();
    f = 9 + PBIT + sb; len = wb * f * cd; per = len + 3; total = 3 + n * per + 4;
    n_rd = 0; n_pulse = 0; n_busy = 0; load_next = 0; have_b = 0; e_b = 0; nxt = 0;
    got_bytes.delete(); trace.delete();
    sel = s;
    @(negedge clk);
    for (int i = 0; i < total; i++) begin
      if (i > 0) @(negedge clk);
      e_rd    = (i >= 1) && ((i - 1) % per == 0) && ((i - 1) / per < n);
      e_busy  = (i >= 1) && ((i - 1) / per < n) && ((i - 1) % per < len + 2);
      e_tx    = 1'b1;
      e_pulse = 1'b0;
      j = i - 3;
      if (j >= 0 && j / per < n && j % per < len) begin
        m = j % per; r = m % (f * cd); bp = r / cd;
        cur_b = get_byte(words[j / per], wb, msb, m / (f * cd));
        e_tx = exp_bit(cur_b, bp, podd);
        if (r == 0) begin e_pulse = 1'b1; e_b = cur_b; have_b = 1'b1; end
      end
      trace.push_back(tx_s);
      if (rd_s) n_rd++;
      if (busy_s) n_busy++;
      if (pulse_s) begin n_pulse++; got_bytes.push_back(dout_s); end
      checks++; if (tx_s !== e_tx) begin errors++; $display("FAIL %s tx cyc=%0d got %b exp %b", tag, i, tx_s, e_tx); end
      checks++; if (rd_s !== e_rd) begin errors++; $display("FAIL %s rd_en cyc=%0d got %b exp %b", tag, i, rd_s, e_rd); end
      checks++; if (pulse_s !== e_pulse) begin errors++; $display("FAIL %s pulse cyc=%0d got %b exp %b", tag, i, pulse_s, e_pulse); end
      checks++; if (busy_s !== e_busy) begin errors++; $display("FAIL %s busy cyc=%0d got %b exp %b", tag, i, busy_s, e_busy); end
      if (have_b) begin
        checks++; if (dout_s !== e_b) begin errors++; $display("FAIL %s data_out cyc=%0d got %h exp %h", tag, i, dout_s, e_b); end
      end
      if (rd_s && fifo.size() > 0) begin
        nxt = fifo.pop_front(); load_next = 1'b1; din = {$urandom, $urandom};
      end else if (load_next) begin
        din = nxt; load_next = 1'b0;
      end else begin
        din = {$urandom, $urandom};
      end
      empty_v = (fifo.size() == 0);
    end
    empty_v = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      #1;
      checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL reset tx dut=%0d got %b exp 1", k, tx_s); end
      checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL reset rd_en dut=%0d got %b exp 0", k, rd_s); end
      checks++; if (pulse_s !== 1'b0) begin errors++; $display("FAIL reset pulse dut=%0d got %b exp 0", k, pulse_s); end
      checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset busy dut=%0d got %b exp 0", k, busy_s); end
      checks++; if (dout_s !== 8'h00) begin errors++; $display("FAIL reset data_out dut=%0d got %h exp 00", k, dout_s); end
    end
  endtask

  task automatic test_defaults();
    int nr, np, nb;
    logic [7:0] exp_b [4];
    logic       exp_f [9];
    exp_b = '{8'h22, 8'h55, 8'h66, 8'h33};
    exp_f = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    wq.delete(); wq.push_back(64'h22556633);
    run_words(2'd0, 8, 4, 1, 1, 0, "defaults", nr, np, nb);
    checks++; if (nr !== 1) begin errors++; $display("FAIL defaults rd_count got %0d exp 1", nr); end
    checks++; if (np !== 4) begin errors++; $display("FAIL defaults pulse_count got %0d exp 4", np); end
    checks++; if (nb !== 2 + 4 * (10 + PBIT) * 8) begin errors++; $display("FAIL defaults busy_cycles got %0d exp %0d", nb, 2 + 4 * (10 + PBIT) * 8); end
    for (int k = 0; k < 4 && k < got_bytes.size(); k++) begin
      checks++; if (got_bytes[k] !== exp_b[k]) begin errors++; $display("FAIL defaults byte%0d got %h exp %h", k, got_bytes[k], exp_b[k]); end
    end
    for (int k = 0; k < 9; k++) begin
      checks++; if (trace[3 + 8*k + 4] !== exp_f[k]) begin errors++; $display("FAIL defaults frame_bit%0d got %b exp %b", k, trace[3 + 8*k + 4], exp_f[k]); end
    end
  endtask

  task automatic test_lsb_first();
    int nr, np, nb;
    logic [7:0] exp_b [4];
    exp_b = '{8'h33, 8'h66, 8'h55, 8'h22};
    wq.delete(); wq.push_back(64'h22556633);
    run_words(2'd1, 4, 4, 0, 1, 1, "lsb_first", nr, np, nb);
    checks++; if (np !== 4) begin errors++; $display("FAIL lsb_first pulse_count got %0d exp 4", np); end
    for (int k = 0; k < 4 && k < got_bytes.size(); k++) begin
      checks++; if (got_bytes[k] !== exp_b[k]) begin errors++; $display("FAIL lsb_first byte%0d got %h exp %h", k, got_bytes[k], exp_b[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int nr, np, nb, len;
    len = 4 * (10 + PBIT) * 8;
    wq.delete(); wq.push_back(64'h01020304); wq.push_back(64'hA5A5A5A5);
    run_words(2'd0, 8, 4, 1, 1, 0, "back_to_back", nr, np, nb);
    checks++; if (nr !== 2) begin errors++; $display("FAIL back_to_back rd_count got %0d exp 2", nr); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (trace[3 + len + k] !== 1'b1) begin errors++; $display("FAIL back_to_back gap%0d got %b exp 1", k, trace[3 + len + k]); end
    end
    checks++; if (trace[3 + len + 3] !== 1'b0) begin errors++; $display("FAIL back_to_back start2 got %b exp 0", trace[3 + len + 3]); end
  endtask

  task automatic test_stop_bits();
    int nr, np, nb;
    wq.delete(); wq.push_back({$urandom, $urandom});
    run_words(2'd2, 4, 2, 1, 2, 0, "stop_bits", nr, np, nb);
    checks++; if (nb !== 2 + 2 * (11 + PBIT) * 4) begin errors++; $display("FAIL stop_bits busy_cycles got %0d exp %0d", nb, 2 + 2 * (11 + PBIT) * 4); end
  endtask

  task automatic test_parity();
    int nr, np, nb;
    wq.delete(); wq.push_back(64'h07);
    run_words(2'd3, 5, 1, 1, 1, 0, "parity", nr, np, nb);
    checks++; if (nb !== 2 + (10 + PBIT) * 5) begin errors++; $display("FAIL parity busy_cycles got %0d exp %0d", nb, 2 + (10 + PBIT) * 5); end
    checks++; if (trace[3 + 9*5 + 2] !== 1'b1) begin errors++; $display("FAIL parity bit9 got %b exp 1", trace[3 + 9*5 + 2]); end
  endtask

  task automatic test_random();
    int nr, np, nb;
    for (int k = 0; k < 4; k++) begin
      wq.delete();
      for (int w = 0; w < 3; w++) wq.push_back({$urandom, $urandom});
      case (k)
        0: run_words(2'd0, 8, 4, 1, 1, 0, "random_a", nr, np, nb);
        1: run_words(2'd1, 4, 4, 0, 1, 1, "random_b", nr, np, nb);
        2: run_words(2'd2, 4, 2, 1, 2, 0, "random_c", nr, np, nb);
        default: run_words(2'd3, 5, 1, 1, 1, 0, "random_d", nr, np, nb);
      endcase
      checks++; if (nr !== 3) begin errors++; $display("FAIL random dut=%0d rd_count got %0d exp 3", k, nr); end
    end
  endtask

  task automatic test_reset_midframe();
    int hit;
    hit = 3 + 2 * (10 + PBIT) * 8 + 8 + 3;
    sel = 2'd0;
    @(negedge clk);
    for (int i = 0; i <= hit; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) empty_v = 1'b0;
      else if (i == 1) begin empty_v = 1'b1; din = {$urandom, $urandom}; end
      else if (i == 2) din = 64'hFFFF00FF;
      else din = {$urandom, $urandom};
    end
    checks++; if (tx_s !== 1'b0) begin errors++; $display("FAIL midframe pre_tx got %b exp 0", tx_s); end
    checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL midframe pre_busy got %b exp 1", busy_s); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL midframe rst_tx got %b exp 1", tx_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL midframe rst_busy got %b exp 0", busy_s); end
    checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL midframe rst_rd_en got %b exp 0", rd_s); end
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL midframe idle_tx cyc=%0d got %b exp 1", i, tx_s); end
      checks++; if (pulse_s !== 1'b0) begin errors++; $display("FAIL midframe idle_pulse cyc=%0d got %b exp 0", i, pulse_s); end
      checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL midframe idle_rd_en cyc=%0d got %b exp 0", i, rd_s); end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_defaults();
    test_lsb_first();
    test_back_to_back();
    test_stop_bits();
    test_parity();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Parametrised UART transmitter that pops N-byte words from a standard-read FIFO (1-cycle read latency) and sends each word as WORD_BYTES back-to-back serial frames, LSB-first bits.
- Configurable byte order, baud divider, stop-bit count and optional parity.
- Sits between the packet FIFO and the board TX pin; exposes a per-byte strobe and the byte in flight for debug and monitor logic.

Parameters:
- CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); values < 2 unsupported.
- WORD_BYTES, 4, bytes per FIFO word (1..8).
- MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant byte first.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd); ignored otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  8*WORD_BYTES  FIFO read data, valid the cycle after rd_en.
- empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO read strobe, one cycle per word.
- tx  out  1  serial line, idle high.
- data_out  out  8  byte currently being framed.
- pulse  out  1  one-cycle strobe on the first cycle of each start bit.
- busy  out  1  high from rd_en through the last stop bit of the word.

Behaviour:
- Reset values (synchronous, all registered outputs): tx=1, rd_en=0, pulse=0, busy=0, data_out=8'h00, state=IDLE, counters=0, shift register=0.
- Reset mid-frame: on the next edge tx=1 and state=IDLE; the partial word is discarded and no further rd_en is issued for it.
- States: IDLE, READ, LOAD, START, DATA, PAR, STOP.
- IDLE: if empty==0 -> READ. Otherwise stay, tx=1.
- READ: rd_en=1 for exactly this cycle, busy=1 -> LOAD.
- LOAD: latch data_in into the word register, byte index=0 -> START.
- START: tx=0 for CLK_DIV cycles.
  - On entry, pulse=1 for one cycle and data_out = selected byte.
  - Byte selection: MSB_FIRST=1 -> byte WORD_BYTES-1-index; MSB_FIRST=0 -> byte index.
  - -> DATA.
- DATA: 8 bits, LSB first, each held CLK_DIV cycles -> PAR if parity compiled in, else STOP.
- PAR: one bit, CLK_DIV cycles.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
  - If index < WORD_BYTES-1: index+1 -> START, with no gap cycles between frames.
  - Else: busy=0 -> IDLE.
- Baud counter runs 0..CLK_DIV-1 and advances bit position at wrap. Every bit is exactly CLK_DIV cycles; no fractional divide.
- Latency: empty sampled low at edge t -> rd_en high in cycle t+1 -> data captured at t+2 -> tx falls at t+3 with pulse.
- Back-to-back words: a minimum of 3 idle-high cycles (IDLE, READ, LOAD) between the last stop bit and the next start bit.
- Word duration: WORD_BYTES*(9+P+STOP_BITS)*CLK_DIV cycles, P = 1 if parity is compiled in, else 0.
- empty is sampled only in IDLE. Changes during a word are ignored, and rd_en is never asserted while busy outside READ.
- data_in is sampled only in LOAD; changes at any other time have no effect.
- data_out holds the last byte after the word ends, until the next START or reset.

Optional Feature:
- Macro UART_WORD_TX_PARITY_EN.
- Defined: PAR state is inserted after the 8 data bits. Parity bit = XOR of the 8 data bits; it is inverted when PARITY_ODD=1.
- Undefined: no PAR state, no parity logic; frame is 8N1 or 8N2; PARITY_ODD has no effect.

Test Plan:
- Defaults with CLK_DIV=8: assert rst, release, data_in=32'h22556633, empty=0 for one cycle.
  - One rd_en pulse.
  - pulse x4 with data_out 0x22, 0x55, 0x66, 0x33.
  - First frame on tx: 0, 0,1,0,0,0,1,0,0, 1, each 8 cycles.
  - Total 320 cycles of frames.
- MSB_FIRST=0, same word -> bytes sent in order 0x33, 0x66, 0x55, 0x22.
- empty held 0 with two words 32'h01020304 then 32'hA5A5A5A5:
  - Exactly two rd_en pulses.
  - Exactly 3 idle-high cycles between the last stop of word 1 and the first start of word 2.
- rst asserted in the DATA state of byte 2:
  - tx=1, busy=0, rd_en=0 on the next edge.
  - After release with empty=1, tx stays high and no pulse occurs.
- UART_WORD_TX_PARITY_EN defined, WORD_BYTES=1, data 8'h07:
  - PARITY_ODD=0 -> parity bit 1.
  - PARITY_ODD=1 -> parity bit 0.
  - Frame is 11 bits * CLK_DIV cycles.
- STOP_BITS=2, CLK_DIV=4, WORD_BYTES=2 -> stop-high period is 8 cycles between frames; word length 2*11*4 = 88 cycles.
